// File: rtl/imm_encoder.sv
// imm_encoder: packs RV32I field bundles into instruction words, FIFO-buffered with a running word address.
// Define IMM_ENC_TRUNC_EN to enqueue out-of-range immediates truncated instead of dropping them.
module imm_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              flush,
    output logic              err_pulse,
    output logic [7:0]        err_count
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              legal, keep, accept, push, pop, bad;
    logic              ok_12, ok_b, ok_j, ok_u;

    assign in_ready  = (cnt != (AW+1)'(DEPTH)) || flush;
    assign out_valid = cnt != '0;
    assign out_inst  = out_valid ? mem[rp] : '0;
    assign out_addr  = addr;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // sign-extension checks: the bits above each field must all equal the field's sign bit
    assign ok_12 = &in_imm[31:11] | ~|in_imm[31:11];
    assign ok_b  = (&in_imm[31:12] | ~|in_imm[31:12]) & ~in_imm[0];
    assign ok_j  = (&in_imm[31:20] | ~|in_imm[31:20]) & ~in_imm[0];
    assign ok_u  = ~|in_imm[11:0];

    always_comb begin
        legal = in_fmt == 3'd0 ? 1'b1 :
                (in_fmt == 3'd1 || in_fmt == 3'd2) ? ok_12 :
                in_fmt == 3'd3 ? ok_b :
                in_fmt == 3'd4 ? ok_u :
                in_fmt == 3'd5 ? ok_j : 1'b0;
        word  = in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
                in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
                in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
                in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
                in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode} :
                {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    end

`ifdef IMM_ENC_TRUNC_EN
    assign keep = in_fmt < 3'd6;
`else
    assign keep = legal;
`endif
    assign push = accept && keep && !flush;
    assign bad  = accept && !legal;

    always_ff @(posedge clk)
        if (push) mem[wp] <= word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            addr      <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            wp        <= flush ? '0 : wp + AW'(push);
            rp        <= flush ? '0 : rp + AW'(pop);
            cnt       <= flush ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
            addr      <= load_en ? (load_addr & ~ADDR_W'(3)) : pop ? addr + ADDR_W'(4) : addr;
            err_pulse <= bad;
            err_count <= (bad && err_count != 8'hff) ? err_count + 8'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed self-checking bench for imm_encoder.
module tb_imm_encoder;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [2:0]  in_fmt = 0;
    logic [6:0]  in_opcode = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [2:0]  in_funct3 = 0;
    logic [6:0]  in_funct7 = 0;
    logic [31:0] in_imm = 0;
    logic        out_valid, out_ready = 0;
    logic [31:0] out_inst, out_addr;
    logic        load_en = 0;
    logic [31:0] load_addr = 0;
    logic        flush = 0, err_pulse;
    logic [7:0]  err_count;
    int checks = 0, failures = 0;

    imm_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .load_en(load_en), .load_addr(load_addr), .flush(flush),
        .err_pulse(err_pulse), .err_count(err_count));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm; in_valid = 1;
        step();
        in_valid = 0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
        checks++; if (out_addr !== 32'h0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
        checks++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", err_pulse, err_count); end
    endtask

    task automatic test_i_basic();
        do_reset();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL i_valid got=%b exp=1", out_valid); end
        checks++; if (out_inst !== 32'h00500093) begin failures++; $display("FAIL i_inst got=%h exp=00500093", out_inst); end
        checks++; if (out_addr !== 32'h0) begin failures++; $display("FAIL i_addr got=%h exp=0", out_addr); end
    endtask

    task automatic test_b_j();
        do_reset();
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        checks++; if (out_inst !== 32'hFE208EE3 || out_addr !== 32'h0) begin failures++; $display("FAIL b_inst got=%h@%h exp=FE208EE3@0", out_inst, out_addr); end
        out_ready = 1;
        step();
        checks++; if (out_inst !== 32'h001000EF || out_addr !== 32'h4) begin failures++; $display("FAIL j_inst got=%h@%h exp=001000EF@4", out_inst, out_addr); end
        step();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h8) begin failures++; $display("FAIL bj_drain got=%b@%h exp=0@8", out_valid, out_addr); end
    endtask

    task automatic test_illegal();
        do_reset();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL ill_i_pulse got=%b exp=1", err_pulse); end
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL ill_b_pulse got=%b exp=1", err_pulse); end
        send(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00001001);
        checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL ill_u_pulse got=%b exp=1", err_pulse); end
        step();
        checks++; if (err_pulse !== 1'b0 || err_count !== 8'd3) begin failures++; $display("FAIL ill_count got=%b/%0d exp=0/3", err_pulse, err_count); end
`ifdef IMM_ENC_TRUNC_EN
        checks++; if (out_inst !== 32'h80000093) begin failures++; $display("FAIL trunc_i got=%h exp=80000093", out_inst); end
        out_ready = 1;
        step();
        checks++; if (out_inst !== 32'h00208163) begin failures++; $display("FAIL trunc_b got=%h exp=00208163", out_inst); end
        step();
        checks++; if (out_inst !== 32'h000010B7) begin failures++; $display("FAIL trunc_u got=%h exp=000010B7", out_inst); end
        step();
        out_ready = 0;
`else
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_dropped got=%b exp=0", out_valid); end
`endif
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, k);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        in_fmt = 3'd1; in_imm = 32'd4; in_valid = 1; out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (out_inst !== 32'h00100093 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop got=%h/%b exp=00100093/1", out_inst, in_ready); end
        step();
        in_valid = 0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_refill got=%b exp=0", in_ready); end
        out_ready = 1;
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_inst !== ((k << 20) | 32'h93)) begin failures++; $display("FAIL full_order%0d got=%b/%h exp=1/%h", k, out_valid, out_inst, (k << 20) | 32'h93); end
            step();
        end
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_load();
        do_reset();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
        out_ready = 1; load_en = 1; load_addr = 32'h1003;
        step();
        load_en = 0;
        checks++; if (out_addr !== 32'h1000) begin failures++; $display("FAIL load_addr got=%h exp=1000", out_addr); end
        step();
        out_ready = 0;
        checks++; if (out_addr !== 32'h1004) begin failures++; $display("FAIL load_next got=%h exp=1004", out_addr); end
    endtask

    task automatic test_saturate();
        do_reset();
        in_fmt = 3'd6; in_valid = 1;
        for (int k = 0; k < 300; k++) step();
        in_valid = 0;
        step();
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL saturate got=%0d exp=255", err_count); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, k);
        in_fmt = 3'd1; in_imm = 32'd9; in_valid = 1; flush = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 0; flush = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL flush_drop got=%b/%0d exp=0/0", out_valid, err_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
        out_ready = 1;
        step();
        out_ready = 0;
        send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        checks++; if (out_addr !== 32'h4 || out_valid !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL pre_rst got=%h/%b/%0d exp=4/1/1", out_addr, out_valid, err_count); end
        #2;
        rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0) begin failures++; $display("FAIL async_fifo got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_inst); end
        checks++; if (out_addr !== 32'h0 || err_pulse !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL async_cnt got=%h/%b/%0d exp=0/0/0", out_addr, err_pulse, err_count); end
        rst = 0;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00500093) begin failures++; $display("FAIL post_rst got=%b/%h exp=1/00500093", out_valid, out_inst); end
    endtask

    initial begin
        #3;
        test_reset();
        rst = 0;
        step();
        test_i_basic();
        test_b_j();
        test_illegal();
        test_full();
        test_load();
        test_saturate();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate generator: packs a field bundle (format, opcode, regs, functs, 32-bit immediate) into a 32-bit RV32I instruction word.
- Checks immediate range and alignment per format, buffers encoded words in a small FIFO, and streams them with a running word address.
- Used by the test-program loader that fills instruction memory ahead of the single-cycle core.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- ADDR_W, 32, width of the address counter and of the out_addr and load_addr ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept; equals !full.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
- in_opcode  in  7  placed in inst[6:0] unchanged.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  32  byte-offset/value immediate, two's complement.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head.
- out_inst  out  32  head instruction word.
- out_addr  out  ADDR_W  address of head word.
- load_en  in  1  load address counter.
- load_addr  in  ADDR_W  new address; bits [1:0] ignored and forced to 0.
- flush  in  1  synchronous: empty the FIFO.
- err_pulse  out  1  one-cycle pulse, registered, on each rejected bundle.
- err_count  out  8  saturating count of rejected bundles.

Behaviour:
- Reset: FIFO empty, out_valid=0, in_ready=1, out_inst=0, addr counter=0, err_pulse=0, err_count=0.
- Accept happens when in_valid && in_ready. The encoded word becomes visible at the FIFO tail; if the FIFO was empty it is on out_inst with out_valid=1 the next cycle.
- Pop happens when out_valid && out_ready. The head advances and the address counter increments by 4, wrapping modulo 2^ADDR_W.
- Push and pop in the same cycle are allowed when the FIFO is neither empty nor full; occupancy is unchanged.
- When full, in_ready=0 with no same-cycle bypass.
- Encoding, with rs/rd/funct fields inserted per standard RV32I layout:
  - R: funct7|rs2|rs1|funct3|rd|op; imm ignored.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Legality (all checked on in_imm):
  - I/S: value in -2048..2047.
  - B: value in -4096..4094 and imm[0]=0.
  - J: value in -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - fmt 6/7: always illegal.
- Illegal bundle: still handshaken (consumed) but not enqueued. Next cycle err_pulse=1; err_count increments and saturates at 255.
- load_en: the counter takes load_addr & ~3 next cycle. If a pop occurs in the same cycle, load wins (no +4).
- flush: next cycle the FIFO is empty and out_valid=0. Flush takes priority over a same-cycle push, which is dropped; in_ready stays 1 during flush. Counters and error state are not affected.
- Async reset asserted mid-stream clears everything immediately. The first accept is possible on the first edge after deassertion.

Optional Feature:
- IMM_ENC_TRUNC_EN defined: range and alignment violations on I/S/B/U/J are still counted and pulsed, but the word is enqueued with the immediate truncated per the field bits above. fmt 6/7 is still dropped.
- Undefined: violations are dropped as specified under Behaviour.

Test Plan:
- Reset, then I bundle op=0010011, rd=1, rs1=0, f3=0, imm=5 → next cycle out_valid=1, out_inst=0x00500093, out_addr=0.
- B op=1100011, rs1=1, rs2=2, f3=0, imm=-4 → out_inst=0xFE208EE3. J op=1101111, rd=1, imm=2048 → 0x001000EF. Both popped: out_addr 0 then 4.
- I imm=2048, then B imm=3, then U imm=0x00001001 → none enqueued, three err_pulses, err_count=3. With IMM_ENC_TRUNC_EN: three words enqueued, err_count=3.
- Hold out_ready=0 and push DEPTH words → in_ready=0 after the DEPTH-th accept. Next cycle assert out_ready and in_valid → one pop then one push, order preserved.
- load_en with load_addr=0x1003 while popping → next out_addr=0x1000; the following pop gives 0x1004. Also check err_count saturates at 255 after 300 illegal bundles.
- Three words queued, flush with in_valid=1 → next cycle out_valid=0 and the concurrent bundle is discarded. Async rst pulse mid-transfer → all outputs return to reset values without a clock edge.
